// File: rtl/pe_2d_driver.sv
// Sequencer for a 2x2 processing-element array: feeds A/B operands over four
// beats, collects four serialized result words, and hands them out with a timeout.
module pe_2d_driver #(
  parameter int W   = 32,
  parameter int TMO = 16,
  parameter int GAP = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [4*W-1:0]   s_a,
  input  logic [4*W-1:0]   s_b,
  output logic             o_en,
  output logic [W-1:0]     o_r1,
  output logic [W-1:0]     o_r2,
  input  logic             i_flag,
  input  logic [2*W-1:0]   i_mat,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [8*W-1:0]   m_c,
  output logic             m_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FEED = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_COLL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_REST = 3'd5;

  localparam int TW = (TMO < 1) ? 1 : $clog2(TMO + 1);
  localparam int RW = (GAP < 1) ? 1 : $clog2(GAP + 1);

  logic [2:0]     state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [1:0]     coll_q, coll_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [RW-1:0]  rest_q, rest_d;
  logic [4*W-1:0] a_q, a_d;
  logic [4*W-1:0] b_q, b_d;
  logic [8*W-1:0] c_q, c_d;
  logic           err_q, err_d;
  logic           flag_q;
  logic           flag_edge;
  logic [1:0]     b_sel;
  int             coll_idx;

  assign flag_edge = i_flag & ~flag_q;
  // B is fed column-major: beat1 carries b10, beat2 carries b01.
  assign b_sel     = {beat_q[0], beat_q[1]};
  assign coll_idx  = int'(coll_q) + 1;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    coll_d  = coll_q;
    tmo_d   = tmo_q;
    rest_d  = rest_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          a_d     = s_a;
          b_d     = s_b;
          c_d     = '0;
          err_d   = 1'b0;
          beat_d  = 2'd0;
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        if (beat_q == 2'd3) begin
          if (flag_edge) begin
            c_d[2*W-1:0] = i_mat;
            coll_d       = 2'd0;
            state_d      = S_COLL;
          end else begin
            tmo_d   = '0;
            state_d = S_WAIT;
          end
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      S_WAIT: begin
        if (flag_edge) begin
          c_d[2*W-1:0] = i_mat;
          coll_d       = 2'd0;
          state_d      = S_COLL;
        end else if (int'(tmo_q) + 1 >= TMO) begin
          err_d   = 1'b1;
          c_d     = '0;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_COLL: begin
        // Words after c00 arrive on consecutive cycles; i_flag is not consulted.
        c_d[coll_idx*2*W +: 2*W] = i_mat;
        if (coll_q == 2'd2) begin
          state_d = S_DONE;
        end else begin
          coll_d = coll_q + 2'd1;
        end
      end
      S_DONE: begin
        if (m_ready) begin
          rest_d  = '0;
          state_d = S_REST;
        end
      end
      S_REST: begin
        if (int'(rest_q) + 1 >= GAP) begin
          state_d = S_IDLE;
        end else begin
          rest_d = rest_q + RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      coll_q  <= '0;
      tmo_q   <= '0;
      rest_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      err_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      coll_q  <= coll_d;
      tmo_q   <= tmo_d;
      rest_q  <= rest_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      err_q   <= err_d;
      flag_q  <= i_flag;
    end
  end

  // s_ready is gated by rstn so it reads 0 throughout reset.
  assign s_ready = rstn & (state_q == S_IDLE);
  assign o_en    = (state_q == S_FEED);
  assign o_r1    = o_en ? a_q[int'(beat_q)*W +: W] : '0;
  assign o_r2    = o_en ? b_q[int'(b_sel)*W +: W] : '0;
  assign m_valid = (state_q == S_DONE);
  assign m_c     = m_valid ? c_q : '0;
  assign m_err   = m_valid & err_q;

endmodule

// File: tb/tb_pe_2d_driver.sv
// Directed bench for pe_2d_driver: feed ordering, result collection, timeout,
// output stall, back-to-back acceptance and reset behaviour.
module tb_pe_2d_driver;
  localparam int W   = 32;
  localparam int TMO = 16;
  localparam int GAP = 3;

  typedef logic [3:0][W-1:0]   mat_t;
  typedef logic [3:0][2*W-1:0] res_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [4*W-1:0] s_a = '0;
  logic [4*W-1:0] s_b = '0;
  logic           o_en;
  logic [W-1:0]   o_r1, o_r2;
  logic           i_flag = 1'b0;
  logic [2*W-1:0] i_mat = '0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [8*W-1:0] m_c;
  logic           m_err;

  int checks = 0;
  int errors = 0;

  pe_2d_driver #(.W(W), .TMO(TMO), .GAP(GAP)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .o_en(o_en), .o_r1(o_r1), .o_r2(o_r2),
    .i_flag(i_flag), .i_mat(i_mat), .m_valid(m_valid), .m_ready(m_ready),
    .m_c(m_c), .m_err(m_err)
  );

  always #5 clk = ~clk;

  mat_t A0, B0;
  res_t R0;

  // Waits (bounded) for s_ready, presents one job, returns at FEED beat0 negedge.
  task automatic accept_job(input mat_t a, input mat_t b);
    int waited = 0;
    while (!s_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: s_ready=%0b required 1", s_ready);
    end
    s_valid = 1'b1; s_a = a; s_b = b;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Samples the four feed beats; returns at the beat3 negedge.
  task automatic sample_feed(output mat_t r1, output mat_t r2, output int en);
    en = 0;
    for (int i = 0; i < 4; i++) begin
      r1[i] = o_r1; r2[i] = o_r2;
      en += int'(o_en);
      if (i < 3) @(negedge clk);
    end
  endtask

  // Drives a flag edge with c00 now, then c01..c11; returns at the DONE negedge.
  task automatic send_words(input res_t w);
    i_flag = 1'b1; i_mat = w[0];
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      i_mat = w[i];
    end
    @(negedge clk);
    i_flag = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_valid) break;
      n++;
    end
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, o_en, m_valid, m_err} !== 4'b0000 || o_r1 !== '0 || o_r2 !== '0 || m_c !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b en=%0b mv=%0b err=%0b r1=%h r2=%h required all 0",
               s_ready, o_en, m_valid, m_err, o_r1, o_r2);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %0b required 1", s_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_normal();
    mat_t r1, r2, e1, e2;
    int en;
    e1 = {32'd4, 32'd3, 32'd2, 32'd1};
    e2 = {32'd8, 32'd6, 32'd7, 32'd5};
    accept_job(A0, B0);
    sample_feed(r1, r2, en);
    checks++;
    if (r1 !== e1 || r2 !== e2 || en != 4) begin
      errors++;
      $display("FAIL feed_order: r1=%h r2=%h en=%0d required r1=%h r2=%h en=4", r1, r2, en, e1, e2);
    end
    @(negedge clk);
    checks++;
    if (o_en !== 1'b0 || o_r1 !== '0 || o_r2 !== '0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_feed_idle: en=%0b r1=%h r2=%h mv=%0b required 0", o_en, o_r1, o_r2, m_valid);
    end
    // Flag drops and re-rises inside COLL; collection must not restart.
    i_flag = 1'b1; i_mat = R0[0];
    @(negedge clk); i_mat = R0[1]; i_flag = 1'b0;
    @(negedge clk); i_mat = R0[2]; i_flag = 1'b1;
    @(negedge clk); i_mat = R0[3];
    @(negedge clk); i_flag = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_err !== 1'b0 || m_c !== R0) begin
      errors++;
      $display("FAIL normal_result: mv=%0b err=%0b m_c=%h required mv=1 err=0 m_c=%h", m_valid, m_err, m_c, R0);
    end
    handshake();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL normal_release: m_valid=%0b required 0", m_valid);
    end
  endtask

  task automatic test_timeout();
    mat_t r1, r2;
    int en, n;
    accept_job(A0, B0);
    sample_feed(r1, r2, en);
    wait_valid(n);
    checks++;
    if (n != TMO || m_err !== 1'b1 || m_c !== '0) begin
      errors++;
      $display("FAIL timeout_path: wait=%0d err=%0b m_c=%h required wait=%0d err=1 m_c=0", n, m_err, m_c, TMO);
    end
    handshake();
  endtask

  task automatic test_stall();
    mat_t r1, r2, a2;
    int en, low, rdy, bad;
    a2 = {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};
    accept_job(A0, B0);
    sample_feed(r1, r2, en);
    @(negedge clk);
    send_words(R0);
    bad = 0;
    s_valid = 1'b1; s_a = a2; s_b = B0;
    for (int k = 0; k < 10; k++) begin
      if (m_valid !== 1'b1 || m_c !== R0 || s_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_stable: %0d unstable cycles required 0", bad);
    end
    handshake();
    low = 0; rdy = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_en) break;
      low++;
      if (s_ready) rdy++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    checks++;
    if (low < GAP || rdy != 1) begin
      errors++;
      $display("FAIL rest_gap: low=%0d ready_cycles=%0d required low>=%0d ready_cycles=1", low, rdy, GAP);
    end
    checks++;
    if (o_en !== 1'b1 || o_r1 !== a2[0]) begin
      errors++; $display("FAIL stall_next_job: en=%0b r1=%h required en=1 r1=%h", o_en, o_r1, a2[0]);
    end
    repeat (3) @(negedge clk);
    send_words(R0);
    handshake();
  endtask

  task automatic test_back_to_back();
    mat_t a1, b1, ea;
    res_t w1, w2;
    int bad, found;
    a1 = {32'd14, 32'd13, 32'd12, 32'd11};
    b1 = {32'd24, 32'd23, 32'd22, 32'd21};
    w1 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h7FFF_0000_1234_5678, 64'hFEDC_BA98_7654_3210};
    w2 = {64'd4, 64'd3, 64'd2, 64'd1};
    while (!s_ready) @(negedge clk);
    s_valid = 1'b1; s_a = a1; s_b = b1;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_r1 !== a1[i] || o_r2 !== b1[{i[0], i[1]}]) bad++;
      s_a = {$urandom, $urandom, $urandom, $urandom};
      if (i < 3) @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL b2b_job1_feed: %0d wrong beats required 0", bad);
    end
    send_words(w1);
    checks++;
    if (m_c !== w1 || m_err !== 1'b0) begin
      errors++; $display("FAIL b2b_full_width: m_c=%h required %h", m_c, w1);
    end
    handshake();
    found = 0; ea = '0;
    for (int k = 0; k < 20; k++) begin
      s_a = {W'(k*4+103), W'(k*4+102), W'(k*4+101), W'(k*4+100)};
      if (s_ready) begin
        ea = s_a; found = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_r1 !== ea[i] || o_en !== 1'b1) bad++;
      s_a = {$urandom, $urandom, $urandom, $urandom};
      if (i == 3) s_valid = 1'b0;
      else @(negedge clk);
    end
    checks++;
    if (found != 1 || bad != 0) begin
      errors++; $display("FAIL b2b_job2_operands: found=%0d bad_beats=%0d required found=1 bad=0", found, bad);
    end
    @(negedge clk);
    send_words(w2);
    checks++;
    if (m_c !== w2) begin
      errors++; $display("FAIL b2b_job2_result: m_c=%h required %h", m_c, w2);
    end
    handshake();
  endtask

  task automatic test_flag_held();
    mat_t r1, r2;
    int en, n;
    while (!s_ready) @(negedge clk);
    i_flag = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL idle_flag_ignored: mv=%0b rdy=%0b required mv=0 rdy=1", m_valid, s_ready);
    end
    accept_job(A0, B0);
    sample_feed(r1, r2, en);
    wait_valid(n);
    checks++;
    if (n != TMO || m_err !== 1'b1 || m_c !== '0) begin
      errors++;
      $display("FAIL flag_held_timeout: wait=%0d err=%0b m_c=%h required wait=%0d err=1 m_c=0", n, m_err, m_c, TMO);
    end
    handshake();
    i_flag = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    mat_t r1, r2;
    int en, seen;
    accept_job(A0, B0);
    sample_feed(r1, r2, en);
    @(negedge clk);
    i_flag = 1'b1; i_mat = R0[0];
    @(negedge clk);
    i_mat = R0[1];
    rstn = 1'b0;
    #1;
    checks++;
    if ({s_ready, o_en, m_valid, m_err} !== 4'b0000 || o_r1 !== '0 || o_r2 !== '0 || m_c !== '0) begin
      errors++;
      $display("FAIL midjob_reset_outputs: rdy=%0b en=%0b mv=%0b err=%0b required all 0", s_ready, o_en, m_valid, m_err);
    end
    i_flag = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL midjob_release_ready: got %0b required 1", s_ready);
    end
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midjob_abandoned: m_valid cycles=%0d required 0", seen);
    end
    accept_job(A0, B0);
    sample_feed(r1, r2, en);
    @(negedge clk);
    send_words(R0);
    checks++;
    if (m_valid !== 1'b1 || m_err !== 1'b0 || m_c !== R0 || r1 !== A0) begin
      errors++; $display("FAIL midjob_next_job: mv=%0b m_c=%h required mv=1 m_c=%h", m_valid, m_c, R0);
    end
    handshake();
  endtask

  initial begin
    A0 = {32'd4, 32'd3, 32'd2, 32'd1};
    B0 = {32'd8, 32'd7, 32'd6, 32'd5};
    R0 = {64'd50, 64'd43, 64'd22, 64'd19};
    test_reset();
    test_normal();
    test_timeout();
    test_stall();
    test_back_to_back();
    test_flag_held();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
